axis_demux_1to8: RTL and testbench
==================================

AXIS_DEMUX_1TO8 -- requirements
Module: axis_demux_1to8

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits of every stream port.
REQ-002 Parameter depth, default 3: width of sel in bits (8 destinations).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sel  input  depth  destination index, 0..7.
REQ-006 data  input  WIDTH  upstream beat payload.
REQ-007 last  input  1  upstream end-of-packet marker.
REQ-008 valid  input  1  upstream beat valid.
REQ-009 ready  output  1  upstream accept; registered (no combinational path from any ready_k).
REQ-010 data_k, k=0..7  output  WIDTH  payload to destination k.
REQ-011 last_k, k=0..7  output  1  end-of-packet marker to destination k.
REQ-012 valid_k, k=0..7  output  1  beat valid to destination k.
REQ-013 ready_k, k=0..7  input  1  accept from destination k.
REQ-014 pkt_active  output  1  high while a packet is open (first beat accepted, last beat not yet accepted).

Function
REQ-015 Upstream transfer occurs on a clock edge with valid=1 and ready=1; downstream transfer k occurs on an edge with valid_k=1 and ready_k=1.
REQ-016 Datapath: one output register (out_valid, out_data, out_last, out_dest) plus one skid register (skid_valid, skid_data, skid_last, skid_dest).
REQ-017 Occupancy states: EMPTY (neither valid), ONE (out only), FULL (out and skid); skid is never valid while out is empty.
REQ-018 data_k = out_data and last_k = out_last for all k; valid_k = out_valid AND (out_dest == k); at most one valid_k is high.
REQ-019 out_ready = ready_k for k = out_dest; all other ready_k are ignored.
REQ-020 Latency: a beat accepted upstream on edge N appears on its valid_k after edge N when the output register is empty or drains on edge N.
REQ-021 EMPTY + upstream transfer -> ONE, beat loaded into output register.
REQ-022 ONE + upstream transfer + downstream transfer -> ONE, new beat replaces output register (full throughput, 1 beat/cycle).
REQ-023 ONE + upstream transfer, no downstream transfer -> FULL, beat loaded into skid register.
REQ-024 ONE + downstream transfer only -> EMPTY.
REQ-025 FULL + downstream transfer -> ONE, skid contents move to output register.
REQ-026 ready = NOT skid_valid, registered; ready is 0 in FULL, so no beat is ever lost or overwritten.
REQ-027 A beat's destination is fixed when it is accepted upstream and travels with it; later sel changes never redirect buffered beats.
REQ-028 Beat order is preserved; a stalled destination blocks all destinations (no reordering, no bypass).
REQ-029 sel and data are sampled only on upstream transfer edges; values while valid=0 or ready=0 have no effect.

Reset
REQ-030 While rst=1: ready=0, all valid_k=0, pkt_active=0, out_valid=0, skid_valid=0; data_k and last_k are 0.
REQ-031 ready rises on the first rising clk edge after rst deasserts.
REQ-032 Reset asserted mid-packet or with buffered beats discards them immediately; no partial packet resumes after reset.

Configuration
REQ-033 Macro AXIS_DEMUX_PKT_LOCK_EN defined: FSM IDLE/IN_PKT; in IDLE an accepted beat takes dest=sel and latches sel into lock_dest; in IN_PKT every accepted beat takes dest=lock_dest regardless of sel.
REQ-034 With the macro, the FSM goes IDLE->IN_PKT on an accepted beat with last=0, returns to IDLE on an accepted beat with last=1, and a single-beat packet (last=1 on first beat) stays in IDLE; pkt_active=1 exactly in IN_PKT.
REQ-035 Macro undefined: every accepted beat takes dest=sel at its own acceptance edge, last is passed through only, and pkt_active is tied 0.

Verification
REQ-036 sel=5, 4 beats 0x0001..0x0004 back-to-back, ready_5=1 -> valid_5 only, 1-cycle latency, 4 beats in 4 cycles, ready stays 1.
REQ-037 ready_2=0 with out holding one beat for dest 2, 2 more beats offered -> second beat goes to skid, ready=0 next cycle, third held upstream; ready_2=1 -> 0xA,0xB,0xC in order.
REQ-038 PKT_LOCK_EN: 3-beat packet starting sel=1, sel switched to 6 on beats 2-3 -> all 3 beats on valid_1, pkt_active 1 until last accepted; next packet with sel=6 -> valid_6.
REQ-039 Without macro, same stimulus -> beat 1 on valid_1, beats 2-3 on valid_6; pkt_active stays 0.
REQ-040 rst asserted while FULL and mid-packet -> all valid_k and ready drop asynchronously; after release ready=1 next edge, first beat uses current sel.

Source files
------------

// File: rtl/axis_demux_1to8_if.sv
// Stream bundle for axis_demux_1to8: one upstream port (with destination select)
// and eight downstream ports carried as packed per-destination vectors.
interface axis_demux_1to8_if #(
  parameter int WIDTH = 16,
  parameter int depth = 3
);
  logic [depth-1:0]          sel;
  logic [WIDTH-1:0]          data;
  logic                      last;
  logic                      valid;
  logic                      ready;
  logic [7:0][WIDTH-1:0]     data_k;
  logic [7:0]                last_k;
  logic [7:0]                valid_k;
  logic [7:0]                ready_k;

  modport master (
    output sel, data, last, valid, ready_k,
    input  ready, data_k, last_k, valid_k
  );

  modport slave (
    input  sel, data, last, valid, ready_k,
    output ready, data_k, last_k, valid_k
  );
endinterface

// File: rtl/axis_demux_1to8.sv
// 1-to-8 AXI-Stream demultiplexer with an output register plus skid register.
// Define AXIS_DEMUX_PKT_LOCK_EN to lock the destination for a whole packet.
module axis_demux_1to8 #(
  parameter int WIDTH = 16,
  parameter int depth = 3
) (
  input  logic             clk,
  input  logic             rst,
  axis_demux_1to8_if.slave bus,
  output logic             pkt_active
);

  localparam int NDEST = 8;

  // Output stage keeps the destination as a one-hot valid vector so valid_k is a flop.
  logic [NDEST-1:0] out_vld_r,    out_vld_s;
  logic [WIDTH-1:0] out_data_r,   out_data_s;
  logic             out_last_r,   out_last_s;
  logic             skid_valid_r, skid_valid_s;
  logic [WIDTH-1:0] skid_data_r,  skid_data_s;
  logic             skid_last_r,  skid_last_s;
  logic [depth-1:0] skid_dest_r,  skid_dest_s;
  logic             ready_r;
  logic             up_fire_s;
  logic             dn_fire_s;
  logic [depth-1:0] beat_dest_s;

  function automatic logic [NDEST-1:0] dest_onehot(input logic [depth-1:0] dest);
    logic [NDEST-1:0] oh;
    oh       = {NDEST{1'b0}};
    oh[dest] = 1'b1;
    return oh;
  endfunction

  assign up_fire_s = bus.valid & ready_r;
  assign dn_fire_s = |(out_vld_r & bus.ready_k);

`ifdef AXIS_DEMUX_PKT_LOCK_EN
  typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} pkt_state_e;

  pkt_state_e       state_r, state_s;
  logic [depth-1:0] lock_dest_r, lock_dest_s;

  // Packet lock state and locked destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      lock_dest_r <= {depth{1'b0}};
    end else begin
      state_r     <= state_s;
      lock_dest_r <= lock_dest_s;
    end
  end

  // First beat of a packet picks sel; the rest follow the locked destination.
  always_comb begin
    state_s     = state_r;
    lock_dest_s = lock_dest_r;
    beat_dest_s = bus.sel;
    case (state_r)
      IDLE: begin
        beat_dest_s = bus.sel;
        if (up_fire_s) begin
          lock_dest_s = bus.sel;
          state_s     = bus.last ? IDLE : IN_PKT;
        end else begin
          state_s     = IDLE;
        end
      end
      IN_PKT: begin
        beat_dest_s = lock_dest_r;
        if (up_fire_s && bus.last) begin
          state_s = IDLE;
        end else begin
          state_s = IN_PKT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign pkt_active = (state_r == IN_PKT);
`else
  assign beat_dest_s = bus.sel;
  assign pkt_active  = 1'b0;
`endif

  // Occupancy transitions EMPTY/ONE/FULL; skid only fills when out is held.
  always_comb begin
    out_vld_s    = out_vld_r;
    out_data_s   = out_data_r;
    out_last_s   = out_last_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_last_s  = skid_last_r;
    skid_dest_s  = skid_dest_r;
    if (out_vld_r == {NDEST{1'b0}}) begin
      if (up_fire_s) begin
        out_vld_s  = dest_onehot(beat_dest_s);
        out_data_s = bus.data;
        out_last_s = bus.last;
      end else begin
        out_vld_s  = {NDEST{1'b0}};
      end
    end else if (skid_valid_r) begin
      if (dn_fire_s) begin
        out_vld_s    = dest_onehot(skid_dest_r);
        out_data_s   = skid_data_r;
        out_last_s   = skid_last_r;
        skid_valid_s = 1'b0;
      end else begin
        skid_valid_s = 1'b1;
      end
    end else begin
      case ({up_fire_s, dn_fire_s})
        2'b11: begin
          out_vld_s  = dest_onehot(beat_dest_s);
          out_data_s = bus.data;
          out_last_s = bus.last;
        end
        2'b10: begin
          skid_valid_s = 1'b1;
          skid_data_s  = bus.data;
          skid_last_s  = bus.last;
          skid_dest_s  = beat_dest_s;
        end
        2'b01: begin
          out_vld_s = {NDEST{1'b0}};
        end
        default: begin
          out_vld_s = out_vld_r;
        end
      endcase
    end
  end

  // Datapath registers; cleared on reset so data_k/last_k read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_r    <= {NDEST{1'b0}};
      out_data_r   <= {WIDTH{1'b0}};
      out_last_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {WIDTH{1'b0}};
      skid_last_r  <= 1'b0;
      skid_dest_r  <= {depth{1'b0}};
      ready_r      <= 1'b0;
    end else begin
      out_vld_r    <= out_vld_s;
      out_data_r   <= out_data_s;
      out_last_r   <= out_last_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_last_r  <= skid_last_s;
      skid_dest_r  <= skid_dest_s;
      ready_r      <= ~skid_valid_s;
    end
  end

  assign bus.ready   = ready_r;
  assign bus.valid_k = out_vld_r;
  assign bus.last_k  = {NDEST{out_last_r}};
  assign bus.data_k  = {NDEST{out_data_r}};

endmodule

// File: tb/tb_axis_demux_1to8.sv
// Bench for axis_demux_1to8: directed vector table, hand sequences for packet lock
// and reset, then random traffic against a two-entry queue reference model.
module tb_axis_demux_1to8;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;
`ifdef AXIS_DEMUX_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic pkt_active;
  int   checks = 0;
  int   failures = 0;

  axis_demux_1to8_if #(.WIDTH(WIDTH), .depth(DEPTH)) bus ();

  axis_demux_1to8 #(.WIDTH(WIDTH), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pkt_active(pkt_active)
  );

  always #5 clk = ~clk;

  // Reference model: at most two buffered beats, FIFO order, head drives its destination.
  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    int               dest;
  } beat_t;

  beat_t q[$];
  bit    rdy_ok;
  bit    in_pkt;
  int    lock_dest;

  typedef struct packed {
    logic             valid;
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
    logic             last;
    logic [7:0]       rk;
    logic [7:0]       ev;
    logic [WIDTH-1:0] ed;
    logic             er;
    logic             ep;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rdy_ok    = 1'b0;
    in_pkt    = 1'b0;
    lock_dest = 0;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] d,
                       input logic l, input logic [7:0] rk);
    bus.valid   = v;
    bus.sel     = s;
    bus.data    = d;
    bus.last    = l;
    bus.ready_k = rk;
  endtask

  task automatic check_model();
    logic [7:0] ev;
    ev = 8'h00;
    if (q.size() > 0) ev[q[0].dest] = 1'b1;
    chk("model_ready", 32'(bus.ready), 32'(rdy_ok && (q.size() < 2)));
    chk("model_valid_k", 32'(bus.valid_k), 32'(ev));
    chk("model_pkt_active", 32'(pkt_active), 32'(in_pkt));
    if (q.size() > 0) begin
      chk("model_data", 32'(bus.data_k[q[0].dest]), 32'(q[0].data));
      chk("model_last", 32'(bus.last_k[q[0].dest]), 32'(q[0].last));
    end
  endtask

  // One clock: update the model from the inputs present at the edge, then compare.
  task automatic tick();
    bit    up;
    bit    dn;
    beat_t b;
    @(posedge clk);
    up = bus.valid && rdy_ok && (q.size() < 2);
    dn = (q.size() > 0) && bus.ready_k[q[0].dest];
    b.data = bus.data;
    b.last = bus.last;
    b.dest = (LOCK && in_pkt) ? lock_dest : int'(bus.sel);
    if (dn) void'(q.pop_front());
    if (up) begin
      q.push_back(b);
      if (!in_pkt) lock_dest = int'(bus.sel);
      in_pkt = LOCK && !bus.last;
    end
    rdy_ok = 1'b1;
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 8'h00);
    model_reset();

    tbl[0]  = '{1'b1, 3'd5, 16'h0001, 1'b0, 8'h20, 8'h20, 16'h0001, 1'b1, LOCK};
    tbl[1]  = '{1'b1, 3'd5, 16'h0002, 1'b0, 8'h20, 8'h20, 16'h0002, 1'b1, LOCK};
    tbl[2]  = '{1'b1, 3'd5, 16'h0003, 1'b0, 8'h20, 8'h20, 16'h0003, 1'b1, LOCK};
    tbl[3]  = '{1'b1, 3'd5, 16'h0004, 1'b1, 8'h20, 8'h20, 16'h0004, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 3'd5, 16'h0000, 1'b0, 8'h20, 8'h00, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 3'd2, 16'h000A, 1'b1, 8'h00, 8'h04, 16'h000A, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 3'd2, 16'h000B, 1'b1, 8'h00, 8'h04, 16'h000A, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 3'd2, 16'h000C, 1'b1, 8'h00, 8'h04, 16'h000A, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 3'd2, 16'h000C, 1'b1, 8'h04, 8'h04, 16'h000B, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 3'd2, 16'h000C, 1'b1, 8'h04, 8'h04, 16'h000C, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 3'd2, 16'h0000, 1'b0, 8'h04, 8'h00, 16'h0000, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_valid_k", 32'(bus.valid_k), 32'd0);
    chk("rst_pkt_active", 32'(pkt_active), 32'd0);
    chk("rst_data_k0", 32'(bus.data_k[0]), 32'd0);
    chk("rst_last_k", 32'(bus.last_k), 32'd0);
    rst = 1'b0;
    model_reset();
    chk("rel_ready_low", 32'(bus.ready), 32'd0);
    tick();
    chk("rel_ready_high", 32'(bus.ready), 32'd1);

    // Back-to-back stream on dest 5, then stall/skid on dest 2
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].valid, tbl[i].sel, tbl[i].data, tbl[i].last, tbl[i].rk);
      tick();
      chk($sformatf("vec%0d_valid_k", i), 32'(bus.valid_k), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'(tbl[i].er));
      chk($sformatf("vec%0d_pkt", i), 32'(pkt_active), 32'(tbl[i].ep));
      if (tbl[i].ev != 8'h00)
        chk($sformatf("vec%0d_data", i), 32'(bus.data_k[tbl[i].sel]), 32'(tbl[i].ed));
    end

    // sel changes mid-packet
    drive(1'b1, 3'd1, 16'h0101, 1'b0, 8'hFF);
    tick();
    chk("lock_b1_valid_k", 32'(bus.valid_k), 32'h02);
    chk("lock_b1_pkt", 32'(pkt_active), 32'(LOCK));
    drive(1'b1, 3'd6, 16'h0102, 1'b0, 8'hFF);
    tick();
    chk("lock_b2_valid_k", 32'(bus.valid_k), LOCK ? 32'h02 : 32'h40);
    chk("lock_b2_pkt", 32'(pkt_active), 32'(LOCK));
    drive(1'b1, 3'd6, 16'h0103, 1'b1, 8'hFF);
    tick();
    chk("lock_b3_valid_k", 32'(bus.valid_k), LOCK ? 32'h02 : 32'h40);
    chk("lock_b3_pkt", 32'(pkt_active), 32'd0);
    drive(1'b1, 3'd6, 16'h0201, 1'b1, 8'hFF);
    tick();
    chk("lock_next_valid_k", 32'(bus.valid_k), 32'h40);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 8'hFF);
    tick();

    // Reset while FULL and mid-packet
    drive(1'b1, 3'd3, 16'h0301, 1'b0, 8'h00);
    tick();
    drive(1'b1, 3'd3, 16'h0302, 1'b0, 8'h00);
    tick();
    chk("full_ready", 32'(bus.ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid_k", 32'(bus.valid_k), 32'd0);
    chk("async_ready", 32'(bus.ready), 32'd0);
    chk("async_pkt", 32'(pkt_active), 32'd0);
    chk("async_data_k3", 32'(bus.data_k[3]), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 3'd4, 16'h0401, 1'b1, 8'hFF);
    chk("post_rst_ready_low", 32'(bus.ready), 32'd0);
    tick();
    chk("post_rst_ready_high", 32'(bus.ready), 32'd1);
    tick();
    chk("post_rst_first_beat", 32'(bus.valid_k), 32'h10);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      logic [7:0] rk;
      rk = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 9) == 0) rk = 8'h00;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
            $urandom_range(0, 3) == 0, rk);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
